uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : every start/data/stop decision is the 2-of-3 majority of the
//               synchronized line at mid-1, mid and mid+1. The decision is taken
//               at mid+1, so all output timing moves one cycle later.
//   undefined : a single sample at mid-bit, no vote logic.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line bit rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   rx_data    out  last correctly framed byte, held until the next good frame
//   rx_valid   out  one-cycle pulse, rx_data newly updated
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   rx_busy    out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 84_000_000,
  parameter int BAUD_RATE = 3000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam int CNT_W       = $clog2(CLK_PER_BIT);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int START_LAST  = HALF_BIT;
`else
  localparam int START_LAST  = HALF_BIT - 1;
`endif
  localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LAST);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLK_PER_BIT - 1);

  generate
    if (CLK_PER_BIT < 4) begin : g_rate_check
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic             rx_s_d;
  logic [1:0]       sync_vld;
  logic             armed;
  logic             rx_bit;
  logic             start_edge;
  logic             cnt_done;
  logic             cnt_clr;
  logic             shift_en;
  logic             load_en;
  logic             ferr_en;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_s_d2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign rx_bit = maj3(rx_s, rx_s_d, rx_s_d2);
`else
  assign rx_bit = rx_s;
`endif

  // Synchronizer and edge history. sync_vld marks when rx_s carries a real
  // line value rather than its reset value; armed then requires the line to
  // be seen high before a falling edge counts, so a line that is low when
  // reset is released never looks like a start bit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_d   <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_s_d2  <= 1'b1;
`endif
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_s_d   <= rx_s;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_s_d2  <= rx_s_d;
`endif
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign start_edge = armed && rx_s_d && !rx_s;
  assign cnt_done   = (state == START) ? (clk_cnt == START_END)
                    : (((state == DATA) || (state == STOP)) && (clk_cnt == BIT_END));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (cnt_done) state_nxt = rx_bit ? IDLE : DATA;
      DATA:    if (cnt_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (cnt_done) state_nxt = rx_bit ? IDLE : RECOVER;
      RECOVER: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    rx_busy  = 1'b1;
    cnt_clr  = 1'b1;
    shift_en = 1'b0;
    load_en  = 1'b0;
    ferr_en  = 1'b0;
    case (state)
      IDLE:    rx_busy = 1'b0;
      START:   cnt_clr = cnt_done;
      DATA: begin
        cnt_clr  = cnt_done;
        shift_en = cnt_done;
      end
      STOP: begin
        cnt_clr = cnt_done;
        load_en = cnt_done && rx_bit;
        ferr_en = cnt_done && !rx_bit;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Counters, shift register and registered output pulses. The clock
  // counter is held at zero outside timed states so it never wraps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift_reg <= {rx_bit, shift_reg[7:1]};
      end
      rx_valid  <= load_en;
      frame_err <= ferr_en;
      if (load_en) begin
        rx_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT  = 28;
  localparam int HALF = 14;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;

  int         vcnt    = 0;
  int         fcnt    = 0;
  int         overlap = 0;
  int         wide    = 0;
  logic       pv      = 1'b0;
  logic       pf      = 1'b0;
  logic [7:0] hist [0:63];

  uart_rx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      hist[vcnt % 64] <= rx_data;
      vcnt <= vcnt + 1;
    end
    if (frame_err) fcnt <= fcnt + 1;
    if (rx_valid && frame_err) overlap <= overlap + 1;
    if ((rx_valid && pv) || (frame_err && pf)) wide <= wide + 1;
    pv <= rx_valid;
    pf <= frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold the line at v for n clocks, inverting it for the single clock at
  // index inv_at (-1 for none).
  task automatic drive_bit(input logic v, input int n, input int inv_at);
    for (int c = 0; c < n; c++) begin
      rx = (c == inv_at) ? ~v : v;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int inv_at);
    drive_bit(1'b0, BIT, -1);
    for (int k = 0; k < 8; k++) drive_bit(b[k], BIT, inv_at);
    drive_bit(stop, BIT, -1);
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    int f0;
    logic [7:0] b;
    logic [7:0] vote_exp;

    rx        = 1'b1;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    drive_bit(1'b1, 3, -1);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    sys_rst_n = 1'b1;
    drive_bit(1'b1, 10, -1);

    // single good byte
    v0 = vcnt; f0 = fcnt;
    send_byte(8'hA5, 1'b1, -1);
    drive_bit(1'b1, 10, -1);
    check("a5_valid_count", vcnt - v0, 1);
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_frame_err_count", fcnt - f0, 0);

    // back-to-back bytes
    v0 = vcnt; f0 = fcnt;
    send_byte(8'h00, 1'b1, -1);
    send_byte(8'hFF, 1'b1, -1);
    drive_bit(1'b1, 10, -1);
    check("b2b_valid_count", vcnt - v0, 2);
    check("b2b_first", hist[v0 % 64], 8'h00);
    check("b2b_second", hist[(v0 + 1) % 64], 8'hFF);
    check("b2b_frame_err_count", fcnt - f0, 0);

    // 5-clock glitch on idle line
    v0 = vcnt; f0 = fcnt;
    drive_bit(1'b0, 5, -1);
    check("glitch_busy_high", rx_busy, 1'b1);
    drive_bit(1'b1, HALF + 4 - 5, -1);
    check("glitch_busy_low", rx_busy, 1'b0);
    drive_bit(1'b1, 40, -1);
    check("glitch_valid_count", vcnt - v0, 0);
    check("glitch_frame_err_count", fcnt - f0, 0);

    // framing error followed by a long break
    send_byte(8'h3C, 1'b1, -1);
    drive_bit(1'b1, 10, -1);
    check("pre_ferr_rx_data", rx_data, 8'h3C);
    v0 = vcnt; f0 = fcnt;
    send_byte(8'h55, 1'b0, -1);
    drive_bit(1'b0, 100, -1);
    check("ferr_count", fcnt - f0, 1);
    check("ferr_valid_count", vcnt - v0, 0);
    check("ferr_rx_data_held", rx_data, 8'h3C);
    check("ferr_busy_in_break", rx_busy, 1'b1);
    drive_bit(1'b1, 4, -1);
    check("ferr_busy_after_break", rx_busy, 1'b0);
    drive_bit(1'b1, 10, -1);

    // reset during bit 4 of 0x81, then a clean 0x7E
    v0 = vcnt; f0 = fcnt;
    b = 8'h81;
    drive_bit(1'b0, BIT, -1);
    for (int k = 0; k < 4; k++) drive_bit(b[k], BIT, -1);
    drive_bit(b[4], 10, -1);
    sys_rst_n = 1'b0;
    drive_bit(b[4], 3, -1);
    check("rst_mid_rx_data", rx_data, 8'h00);
    check("rst_mid_busy", rx_busy, 1'b0);
    sys_rst_n = 1'b1;
    drive_bit(b[4], BIT - 13, -1);
    for (int k = 5; k < 8; k++) drive_bit(b[k], BIT, -1);
    drive_bit(1'b1, BIT, -1);
    drive_bit(1'b1, 20, -1);
    send_byte(8'h7E, 1'b1, -1);
    drive_bit(1'b1, 10, -1);
    check("rst_valid_count", vcnt - v0, 1);
    check("rst_rx_data", rx_data, 8'h7E);
    check("rst_frame_err_count", fcnt - f0, 0);

    // one-clock inversion at the mid sample of every data bit
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote_exp = 8'hA5;
`else
    vote_exp = 8'h5A;
`endif
    v0 = vcnt;
    send_byte(8'hA5, 1'b1, HALF);
    drive_bit(1'b1, 10, -1);
    check("midglitch_valid_count", vcnt - v0, 1);
    check("midglitch_rx_data", rx_data, {24'h0, vote_exp});

    check("valid_ferr_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
